// File: rtl/haar_scale_sequencer.sv
// Haar stage scaler: runs lanes 0-3 through one shared external multiplier and
// halves lanes 4-7 internally, then presents the permuted 8-lane block downstream.
module haar_scale_sequencer #(
    parameter logic [14:0] COEF      = 15'd7071,
    parameter int          LANES_MUL = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [95:0] in_data,
    input  logic        scale_en,
    output logic        mul_req,
    output logic [10:0] mul_operand,
    output logic [14:0] mul_coef,
    input  logic        mul_ack,
    input  logic [10:0] mul_result,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [95:0] out_data,
    output logic        busy
);
    localparam int LW = $clog2(LANES_MUL);

    // PACK is the single cycle that assembles out_data before it is offered.
    typedef enum logic [1:0] {IDLE, MUL, PACK, OUT} state_t;

    state_t          state_q;
    logic [LW-1:0]   lane_q;
    logic [LW-1:0]   lane_d;
    logic            lane_last;
    logic [95:0]     blk_q;
    logic            scale_q;
    logic            mul_req_q;
    logic [10:0]     mul_operand_q;
    logic            out_valid_q;
    logic [95:0]     out_data_q;
    logic [95:0]     pack_d;
    logic [10:0]     res_q   [LANES_MUL];
    logic [10:0]     mul_mag [LANES_MUL];
    logic            unused_lsbs;

    genvar gi;
    generate
        for (gi = 0; gi < LANES_MUL; gi++) begin : g_mul_lanes
            assign mul_mag[gi] = blk_q[12*gi +: 11];
            assign pack_d[12*gi +: 12] = {blk_q[12*gi + 11],
                                          scale_q ? res_q[gi] : blk_q[12*gi +: 11]};
        end
        // Upper output lanes take the halved inputs in order 6, 7, 5, 4.
        for (gi = 0; gi < 4; gi++) begin : g_shift_lanes
            localparam int SRC = (gi == 0) ? 6 : (gi == 1) ? 7 : (gi == 2) ? 5 : 4;
            assign pack_d[48 + 12*gi +: 12] = {blk_q[12*SRC + 11], 1'b0, blk_q[12*SRC + 1 +: 10]};
        end
    endgenerate

    // Magnitude LSBs of lanes 4-7 are shifted out and never observed.
    assign unused_lsbs = ^{blk_q[48], blk_q[60], blk_q[72], blk_q[84]};

    assign lane_d    = lane_q + LW'(1);
    assign lane_last = (lane_q == LW'(LANES_MUL - 1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            lane_q        <= '0;
            blk_q         <= '0;
            scale_q       <= 1'b0;
            mul_req_q     <= 1'b0;
            mul_operand_q <= '0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
            for (int k = 0; k < LANES_MUL; k++) begin
                res_q[k] <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        blk_q         <= in_data;
                        scale_q       <= scale_en;
                        lane_q        <= '0;
                        mul_req_q     <= scale_en && (in_data[10:0] != 11'd0);
                        mul_operand_q <= in_data[10:0];
                        state_q       <= scale_en ? MUL : PACK;
                    end
                end
                MUL: begin
                    // A zero-magnitude lane skips the multiplier and resolves in one cycle.
                    if (!mul_req_q || mul_ack) begin
                        res_q[lane_q] <= mul_req_q ? mul_result : 11'd0;
                        if (lane_last) begin
                            mul_req_q <= 1'b0;
                            state_q   <= PACK;
                        end else begin
                            lane_q        <= lane_d;
                            mul_req_q     <= (mul_mag[lane_d] != 11'd0);
                            mul_operand_q <= mul_mag[lane_d];
                        end
                    end
                end
                PACK: begin
                    out_data_q  <= pack_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign mul_req     = mul_req_q;
    assign mul_operand = mul_operand_q;
    assign mul_coef    = COEF;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;

endmodule
